sys_debug_ctrl: RTL
===================

// Module: sys_debug_ctrl
// PURPOSE
//  Parametrised run-control and probe unit for the SYS CPU top.
//  - Selects one of NUM_CH probe channels for the HEX/LCD/LED display path.
//  - Gates CPU progress through cpu_en, which drives the pc/register-file enable.
//  - Provides run, single-step and halt control, plus one PC breakpoint.
//  - Records executed {pc, probe} pairs in a circular trace buffer.
// PARAMETERS
//  NUM_CH       16   number of probe channels on probe_bus
//  DATA_W       32   width of each probe channel
//  PC_W         32   program counter width
//  TRACE_DEPTH  16   trace entries; power of 2, >=2
// PORTS
//  SYS_clk        in   1                 sole clock, rising edge
//  SYS_reset      in   1                 asynchronous, active-high reset
//  probe_bus      in   NUM_CH*DATA_W     channel k at [k*DATA_W +: DATA_W]
//  probe_sel      in   $clog2(NUM_CH)    display/trace channel select
//  pc_in          in   PC_W              PC of the instruction about to execute
//  run_req        in   1                 level; rising edge requests RUN
//  step_req       in   1                 level; rising edge requests one instruction
//  halt_req       in   1                 level; rising edge requests HALT
//  bp_en          in   1                 breakpoint enable
//  bp_addr        in   PC_W              breakpoint PC
//  cpu_en         out  1                 CPU advances one instruction on each cycle this is high
//  dbg_state      out  2                 HALT=0 RUN=1 STEP=2 BREAK=3
//  probe_out      out  DATA_W            registered copy of the selected channel
//  trace_rd       in   1                 pop the oldest trace entry
//  trace_data     out  PC_W+DATA_W       {pc, probe} of the oldest entry; valid when trace_valid=1
//  trace_valid    out  1                 buffer not empty
//  trace_count    out  $clog2(TRACE_DEPTH)+1   number of stored entries
//  trace_ovf      out  1                 sticky; an entry was overwritten
// BEHAVIOUR
//  - Reset values: dbg_state=HALT, cpu_en=0, probe_out=0, trace_count=0, trace_valid=0,
//    trace_ovf=0, trace_data=0, all edge-detect registers=0. Reset is honoured mid-operation.
//  - Requests are edge-detected against a registered copy of each input (1-cycle latency).
//    Simultaneous edges resolve by priority halt > step > run.
//  - bp_hit = bp_en & (pc_in==bp_addr) & ~skip.
//  - cpu_en (combinational) = (RUN & ~bp_hit) | STEP.
//  - FSM transitions:
//    - HALT/BREAK: step edge -> STEP; run edge -> RUN.
//    - STEP: always -> HALT after exactly one cycle (exactly one cpu_en pulse).
//    - RUN: bp_hit -> BREAK, and the instruction at bp_addr is NOT executed.
//      halt edge -> HALT, effective on the next cycle.
//    - Any state: halt edge -> HALT.
//  - skip flag:
//    - Set when leaving BREAK.
//    - Cleared after the first cpu_en cycle.
//    - Effect: resume or step from a breakpoint executes the bp instruction once instead of re-breaking.
//  - probe_out <= probe_bus[probe_sel] every cycle. An out-of-range probe_sel yields 0.
//  - Trace push: every cycle with cpu_en=1, write {pc_in, selected probe}.
//  - Trace pop: trace_rd with trace_valid=1 advances the read pointer.
//    trace_rd when empty is ignored.
//  - Full + push: the oldest entry is overwritten (rd pointer advances) and trace_ovf is set.
//    trace_ovf is cleared only by reset.
//  - Full + push + pop in the same cycle: one entry is dropped, count stays at DEPTH,
//    and ovf is set.
//  - Not full + push + pop: count is unchanged.
//  - Pointers wrap modulo TRACE_DEPTH.
//  - trace_data is registered: it shows the new head one cycle after a pop or after the first push.
// CONFIGURATION
//  SYS_DBG_TRACE_EN
//  - Defined: the trace buffer is built as described above.
//  - Undefined: no storage is built; trace_data=0, trace_valid=0, trace_count=0, trace_ovf=0,
//    and trace_rd is ignored.
//  Run control and probe_out are identical in both builds.
// STRUCTURE
//  - Shared package sys_dbg_pkg holds:
//    - the state encodings DBG_HALT, DBG_RUN, DBG_STEP, DBG_BREAK;
//    - the dbg_state width constant;
//    - the trace entry layout (PC field in the upper bits).
//  - Sub-module sys_dbg_trace_buf is the circular overwrite buffer
//    (push/pop/count/ovf), parametrised by WIDTH and DEPTH.
//  - The FSM, edge detection and probe mux live in the top.
// TESTING
//  1. Reset while in RUN: assert SYS_reset -> dbg_state=0, cpu_en=0 immediately (asynchronous);
//     trace_count=0.
//  2. Step from HALT: one step_req edge -> cpu_en high for exactly 1 cycle, dbg_state 2 then 0,
//     trace_count=1, trace_data={pc_in, probe}.
//  3. Breakpoint:
//     - bp_addr=0x10, RUN with pc stepping 0x0,0x4,... -> cpu_en drops on the cycle pc_in=0x10,
//       dbg_state=3, and 0x10 is not traced.
//     - run edge -> 0x10 executes, then run continues.
//  4. Overflow (DEPTH=16): 20 pushes with no reads -> trace_count=16, trace_ovf=1,
//     and the first pop returns the 5th pushed PC.
//  5. Priority: halt, step and run edges in the same cycle during RUN -> HALT.
//     Step and run together in HALT -> exactly one cpu_en pulse.
//  6. Probe mux: NUM_CH=16, channel k = k*0x11111111.
//     - probe_sel=5 -> probe_out=0x55555555 one cycle later.
//     - Undefine SYS_DBG_TRACE_EN -> trace outputs stay 0.

Source files
------------

// File: rtl/sys_dbg_pkg.sv
// sys_dbg_pkg: shared run-control encodings and trace entry layout for the
// SYS CPU debug controller.
// Trace entries are packed as {pc, probe}: the PC occupies the upper PC_W bits
// and the selected probe word the lower DATA_W bits.
package sys_dbg_pkg;

  localparam int DBG_STATE_W = 2;

  typedef enum logic [DBG_STATE_W-1:0] {
    DBG_HALT  = 2'd0,
    DBG_RUN   = 2'd1,
    DBG_STEP  = 2'd2,
    DBG_BREAK = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/sys_dbg_trace_buf.sv
// sys_dbg_trace_buf: circular overwrite buffer. When full, a push replaces the
// oldest entry and sets the sticky overflow flag. rdata_o is registered and
// always shows the current head (0 when empty).
module sys_dbg_trace_buf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   ovf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             full, empty, pop_eff;

  // Pointer/count bookkeeping and look-ahead of the next head entry.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    pop_eff  = pop_i & ~empty;
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = (pop_eff | (push_i & full)) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i & ~full & ~pop_eff)
      count_d = count_q + CNT_W'(1);
    else if (pop_eff & ~push_i)
      count_d = count_q - CNT_W'(1);
    ovf_d   = ovf_q | (push_i & full);
    rdata_d = '0;
    // The new head may be the slot being written this cycle.
    if (count_d != '0)
      rdata_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = (count_q != '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/sys_debug_ctrl.sv
// sys_debug_ctrl: run/step/halt control, PC breakpoint, probe mux and trace
// capture for the SYS CPU. The trace buffer is only built when the macro
// SYS_DBG_TRACE_EN is defined; otherwise all trace outputs read 0.
//
// state     | meaning
// DBG_HALT  | CPU stopped, waiting for run or step request
// DBG_RUN   | CPU free-running until halt request or breakpoint
// DBG_STEP  | one instruction enabled, then back to HALT
// DBG_BREAK | stopped at bp_addr; the bp instruction has not executed
module sys_debug_ctrl
  import sys_dbg_pkg::*;
#(
  parameter int NUM_CH      = 16,
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int TRACE_DEPTH = 16,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W      = $clog2(TRACE_DEPTH) + 1
) (
  input  logic                     SYS_clk,
  input  logic                     SYS_reset,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]         probe_sel,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     run_req,
  input  logic                     step_req,
  input  logic                     halt_req,
  input  logic                     bp_en,
  input  logic [PC_W-1:0]          bp_addr,
  output logic                     cpu_en,
  output logic [DBG_STATE_W-1:0]   dbg_state,
  output logic [DATA_W-1:0]        probe_out,
  input  logic                     trace_rd,
  output logic [PC_W+DATA_W-1:0]   trace_data,
  output logic                     trace_valid,
  output logic [CNT_W-1:0]         trace_count,
  output logic                     trace_ovf
);

  dbg_state_e        state_q, state_d;
  logic              run_q, step_q, halt_q;
  logic              skip_q, skip_d;
  logic              run_edge, step_edge, halt_edge, bp_hit;
  logic [DATA_W-1:0] probe_q, sel_data;

  assign run_edge  = run_req  & ~run_q;
  assign step_edge = step_req & ~step_q;
  assign halt_edge = halt_req & ~halt_q;
  assign bp_hit    = bp_en & (pc_in == bp_addr) & ~skip_q;
  assign cpu_en    = ((state_q == DBG_RUN) & ~bp_hit) | (state_q == DBG_STEP);

  // Probe channel select; unmatched selects give 0.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(probe_sel) == k) sel_data = probe_bus[k*DATA_W +: DATA_W];
  end

  // Next-state logic with halt > step > run priority, plus breakpoint skip.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (halt_edge) begin
      state_d = DBG_HALT;
    end else begin
      case (state_q)
        DBG_HALT, DBG_BREAK: begin
          if (step_edge)     state_d = DBG_STEP;
          else if (run_edge) state_d = DBG_RUN;
        end
        DBG_STEP: state_d = DBG_HALT;
        DBG_RUN:  if (bp_hit) state_d = DBG_BREAK;
        default:  state_d = DBG_HALT;
      endcase
    end
    // Leaving BREAK lets the bp instruction execute once before re-arming.
    if ((state_q == DBG_BREAK) && (state_d != DBG_BREAK)) skip_d = 1'b1;
    else if (cpu_en)                                      skip_d = 1'b0;
  end

  // State, request history and probe register.
  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= DBG_HALT;
      run_q   <= 1'b0;
      step_q  <= 1'b0;
      halt_q  <= 1'b0;
      skip_q  <= 1'b0;
      probe_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_req;
      step_q  <= step_req;
      halt_q  <= halt_req;
      skip_q  <= skip_d;
      probe_q <= sel_data;
    end
  end

  assign dbg_state = state_q;
  assign probe_out = probe_q;

`ifdef SYS_DBG_TRACE_EN
  sys_dbg_trace_buf #(
    .WIDTH (PC_W + DATA_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk_i   (SYS_clk),
    .rst_i   (SYS_reset),
    .push_i  (cpu_en),
    .pop_i   (trace_rd),
    .wdata_i ({pc_in, sel_data}),
    .rdata_o (trace_data),
    .valid_o (trace_valid),
    .count_o (trace_count),
    .ovf_o   (trace_ovf)
  );
`else
  logic unused_trace_rd;
  assign unused_trace_rd = trace_rd;
  assign trace_data      = '0;
  assign trace_valid     = 1'b0;
  assign trace_count     = '0;
  assign trace_ovf       = 1'b0;
`endif

endmodule
